// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioning slice: debounce states,
// board button indices and debounce lengths for hardware and simulation.
package button_conditioner_pkg;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } btn_state_e;

  localparam int unsigned BTN_GO     = 0;
  localparam int unsigned BTN_GREEN  = 1;
  localparam int unsigned BTN_RED    = 2;
  localparam int unsigned BTN_YELLOW = 3;
  localparam int unsigned BTN_BLUE   = 4;

  // 10 ms at 100 MHz on the board; a short window keeps simulations fast.
  localparam int unsigned DEBOUNCE_SYNTH = 1000000;
  localparam int unsigned DEBOUNCE_SIM   = 4;

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// Single-button conditioner: two-flop synchroniser, stability counter and a
// RELEASED/PRESSED state machine emitting registered press/release strobes.
module debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_SYNTH,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  assign sync = sync_q[1];

  // Any sample matching the current level restarts the count from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RELEASED;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (sync == state) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt <= '0;
        if (state == RELEASED) begin
          state <= PRESSED;
          press <= 1'b1;
        end else begin
          state <= RELEASED;
          rel   <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = (state == PRESSED);

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw board buttons into clean levels and press/release strobes,
// plus a lowest-index-wins encoding of the buttons pressed this cycle.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_SYNTH,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned CODE_W          = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               press_valid,
  output logic [CODE_W-1:0]  press_code
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

  logic found;

  always_comb begin
    press_valid = |btn_press;
    press_code  = '0;
    found       = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (btn_press[i] && !found) begin
        press_code = CODE_W'(i);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-conditioning stage directly upstream of the ready/set/go sequencer and the game FSM. It takes raw, bouncing board push-buttons (Go plus the four Simon colour buttons) and synchronises and debounces each one. It produces clean levels, single-cycle press and release strobes, and an encoded press event that downstream logic consumes on the system clock.

Parameters:
NUM_BTN, 5, number of buttons conditioned (bit 0 = Go, bits 1..4 = colour buttons)
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles needed to accept a change (10 ms at 100 MHz)
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
CODE_W, 3, width of press_code; must satisfy 2^CODE_W >= NUM_BTN

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
btn_raw  input  NUM_BTN  raw asynchronous button inputs, 1 = pressed
btn_level  output  NUM_BTN  debounced button level
btn_press  output  NUM_BTN  one-cycle strobe on each debounced 0->1 transition
btn_release  output  NUM_BTN  one-cycle strobe on each debounced 1->0 transition
press_valid  output  1  one-cycle strobe: at least one btn_press bit set this cycle
press_code  output  CODE_W  index of lowest-numbered button in btn_press when press_valid=1, else 0

Behaviour:
- Reset (reset=0, async): synchroniser flops, counters, btn_level, btn_press, btn_release, press_valid and press_code all go to 0 immediately. Reset release is not re-timed inside this block.
- Synchroniser: two-flop chain per bit. sync[i] is btn_raw[i] delayed 2 clocks. No logic sits between the flops.
- Per-button debounce cell, 2-state FSM keyed on btn_level[i] (RELEASED=0, PRESSED=1) plus counter cnt[i]:
  - sync[i]==btn_level[i]: cnt <= 0.
  - sync[i]!=btn_level[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync[i]!=btn_level[i] and cnt == DEBOUNCE_CYCLES-1: btn_level toggles, cnt <= 0, and the matching press/release strobe is registered high on the same edge.
- Any single-cycle glitch back to the old level restarts the count from 0. There is no partial credit.
- Latency: if btn_raw rises just before edge 1 and stays stable, btn_level and btn_press go high after edge 2+DEBOUNCE_CYCLES. btn_press is high for exactly one cycle. Release timing is symmetric.
- Strobes are registered. Each strobe is high for exactly one clk cycle per accepted transition and never two cycles in a row for the same bit.
- press_valid/press_code are combinational from the registered btn_press, with fixed priority: lowest index wins. Other bits pressed in the same cycle still appear in btn_press but are not encoded.
- Simultaneous independent buttons are fully independent. Cells share no state.
- Counter saturation cannot occur (bounded by DEBOUNCE_CYCLES-1). There is no wrap.
- Button held through reset: after reset deasserts, btn_level=0, so a held button produces a normal press strobe DEBOUNCE_CYCLES+2 cycles later. This is intended: downstream treats it as a new press.
- Reset asserted mid-count: the count is discarded and no strobe is emitted.

Decomposition:
- Shared package: state encodings RELEASED/PRESSED, BTN_GO=0 and colour-button index constants, and default DEBOUNCE_CYCLES for synthesis and simulation (4 for sim).
- One sub-module, debounce_cell: a single-bit synchroniser, counter and FSM, generating level/press/release. It is instantiated NUM_BTN times.
- The top level holds the generate loop and the priority encoder.

Test Plan:
(All with DEBOUNCE_CYCLES=4, NUM_BTN=5.)
1. Reset: hold reset=0 with btn_raw=5'b11111 -> all outputs 0. Release reset, keep inputs high -> btn_level=5'b11111 and btn_press=5'b11111 after edge 6, press_valid=1, press_code=0, for one cycle only.
2. Clean press: btn_raw[0] 0->1 before edge 1 -> btn_press[0]=1 only in the cycle after edge 6. Drop btn_raw[0] -> btn_release[0]=1 one cycle, 6 edges later.
3. Bounce: btn_raw[2] toggles 1,0,1,0 on successive cycles, then holds 1 -> no strobe until 4 stable synced cycles. Exactly one btn_press[2] pulse; press_code=2.
4. Glitch rejection: btn_raw[3] high for 3 cycles, then low -> btn_level[3] stays 0 and no strobe ever.
5. Simultaneous: btn_raw[4] and btn_raw[1] rise on the same edge -> btn_press=5'b10010 for one cycle, press_valid=1, press_code=1.
6. Reset mid-count: btn_raw[0] high, assert reset=0 after 3 synced cycles -> outputs clear asynchronously and no strobe. After release, the press arrives a full 6 edges later.
